otter_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the OTTER MCU's IOBUS, downstream of the CPU. It decodes the CPU's IOBUS_ADDR/IOBUS_OUT/IOBUS_WR outputs, buffers written bytes in an 8-entry FIFO, and serializes them as 8N1 frames. It drives status back onto the CPU's IOBUS_IN path and raises a one-cycle INTR pulse when transmission drains.

---
 rtl/otter_uart_tx_if.sv | 21 ++
 rtl/otter_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_otter_uart_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_uart_tx_if.sv
// rtl/otter_uart_tx_if.sv - OTTER IOBUS register port bundle for the UART transmitter
interface otter_uart_tx_if;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] IOBUS_IN;

   modport master (
      output IOBUS_ADDR,
      output IOBUS_OUT,
      output IOBUS_WR,
      input  IOBUS_IN
   );

   modport slave (
      input  IOBUS_ADDR,
      input  IOBUS_OUT,
      input  IOBUS_WR,
      output IOBUS_IN
   );
endinterface

// File: rtl/otter_uart_tx.sv
// rtl/otter_uart_tx.sv - memory-mapped 8N1 UART transmitter with 8-entry FIFO
// DATA/STATUS/CTRL registers at BASE_ADDR, +4, +8; INTR pulses when the line drains.
module otter_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h1100_0040,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic           CLK,
   input  logic           RESET,
   otter_uart_tx_if.slave bus,
   output logic           TX,
   output logic           INTR
);

   localparam int              BW         = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]   BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]      FULL_COUNT = 4'(FIFO_DEPTH);
   localparam logic [31:0]     ADDR_DATA   = BASE_ADDR;
   localparam logic [31:0]     ADDR_STATUS = BASE_ADDR + 32'd4;
   localparam logic [31:0]     ADDR_CTRL   = BASE_ADDR + 32'd8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [BW-1:0] baud;
   logic [BW-1:0] baud_next;
   logic [2:0]    bit_cnt;
   logic [2:0]    bit_next;
   logic [7:0]    shift;
   logic [7:0]    shift_next;
   logic          intr_next;

   logic [7:0]    mem [8];
   logic [2:0]    wr_ptr;
   logic [2:0]    rd_ptr;
   logic [3:0]    count;
   logic          ovf;
   logic          ie;

   logic          sel_data;
   logic          sel_status;
   logic          sel_ctrl;
   logic          full;
   logic          empty;
   logic          busy;
   logic          push;
   logic          pop;
   logic          baud_done;
   logic          unused_bits;

   assign sel_data   = (bus.IOBUS_ADDR == ADDR_DATA);
   assign sel_status = (bus.IOBUS_ADDR == ADDR_STATUS);
   assign sel_ctrl   = (bus.IOBUS_ADDR == ADDR_CTRL);

   assign full      = (count == FULL_COUNT);
   assign empty     = (count == 4'd0);
   assign busy      = (state != IDLE);
   assign baud_done = (baud == BAUD_LAST);

   // Full is judged on the registered count, so a pop in the same cycle never frees a slot.
   assign push = bus.IOBUS_WR && sel_data && !full;

   assign unused_bits = ^bus.IOBUS_OUT[31:8];

   always_comb begin
      bus.IOBUS_IN = 32'd0;
      if (sel_status) begin
         bus.IOBUS_IN = {23'd0, ovf, count, 1'b0, busy, empty, full};
      end else if (sel_ctrl) begin
         bus.IOBUS_IN = {31'd0, ie};
      end
   end

   always_comb begin
      state_next = state;
      baud_next  = baud + BW'(1);
      bit_next   = bit_cnt;
      shift_next = shift;
      pop        = 1'b0;
      intr_next  = 1'b0;
      TX         = 1'b1;
      case (state)
         IDLE: begin
            baud_next = '0;
            if (!empty) begin
               pop        = 1'b1;
               shift_next = mem[rd_ptr];
               bit_next   = 3'd0;
               state_next = START;
            end
         end
         START: begin
            TX = 1'b0;
            if (baud_done) begin
               baud_next  = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            TX = shift[0];
            if (baud_done) begin
               baud_next  = '0;
               shift_next = {1'b0, shift[7:1]};
               if (bit_cnt == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_cnt + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_next = '0;
               if (!empty) begin
                  pop        = 1'b1;
                  shift_next = mem[rd_ptr];
                  bit_next   = 3'd0;
                  state_next = START;
               end else begin
                  state_next = IDLE;
                  intr_next  = ie;
               end
            end
         end
         default: begin
            baud_next  = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= 3'd0;
         shift   <= 8'd0;
         INTR    <= 1'b0;
      end else begin
         state   <= state_next;
         baud    <= baud_next;
         bit_cnt <= bit_next;
         shift   <= shift_next;
         INTR    <= intr_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET && push) begin
         mem[wr_ptr] <= bus.IOBUS_OUT[7:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= 3'd0;
         rd_ptr <= 3'd0;
         count  <= 4'd0;
         ovf    <= 1'b0;
         ie     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 3'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 3'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
         if (bus.IOBUS_WR && sel_data && full) begin
            ovf <= 1'b1;
         end else if (bus.IOBUS_WR && sel_status) begin
            ovf <= 1'b0;
         end
         if (bus.IOBUS_WR && sel_ctrl) begin
            ie <= bus.IOBUS_OUT[0];
         end
      end
   end

endmodule

// File: tb/tb_otter_uart_tx.sv
// tb/tb_otter_uart_tx.sv - scoreboard bench for otter_uart_tx at CLKS_PER_BIT=4
module tb_otter_uart_tx;

   localparam logic [31:0] BASE = 32'h1100_0040;
   localparam int          CPB  = 4;

   logic CLK;
   logic RESET;
   logic TX;
   logic INTR;

   otter_uart_tx_if bus ();

   otter_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus),
      .TX    (TX),
      .INTR  (INTR)
   );

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         wr_cyc = 0;
   logic [7:0] exp_q [$];
   int         frame_starts [$];
   int         intr_pulses = 0;
   int         intr_high = 0;
   int         intr_cyc = 0;
   logic       intr_prev = 1'b0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: decode every frame on TX and compare to the queued byte.
   initial begin
      logic [39:0] got;
      logic [39:0] want;
      logic [7:0]  b;
      logic        aborted;
      int          start;
      int          k;
      forever begin
         @(negedge CLK);
         if (!RESET && TX == 1'b0) begin
            start   = cyc;
            frame_starts.push_back(start);
            aborted = 1'b0;
            got     = '0;
            for (int c = 0; c < 10 * CPB; c++) begin
               if (c > 0) @(negedge CLK);
               if (RESET) begin
                  aborted = 1'b1;
                  break;
               end
               got[c] = TX;
            end
            if (!aborted) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL frame_unexpected: got frame bits %h at cycle %0d expected no frame", got, start);
               end else begin
                  b = exp_q.pop_front();
                  for (int c = 0; c < 10 * CPB; c++) begin
                     k = c / CPB;
                     want[c] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                  end
                  if (got !== want) begin
                     errors++;
                     $display("FAIL frame_%h: got line %h expected %h", b, got, want);
                  end
               end
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (INTR) begin
         intr_high++;
         if (!intr_prev) begin
            intr_pulses++;
            intr_cyc = cyc;
         end
      end
      intr_prev = INTR;
   end

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic we);
      bus.IOBUS_ADDR = addr;
      bus.IOBUS_OUT  = data;
      bus.IOBUS_WR   = we;
      @(negedge CLK);
      bus.IOBUS_WR   = 1'b0;
      wr_cyc         = cyc;
   endtask

   task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      bus.IOBUS_ADDR = addr;
      #1;
      check32(name, bus.IOBUS_IN, exp);
   endtask

   task automatic send(input logic [7:0] b);
      exp_q.push_back(b);
      bus_wr(BASE, {24'd0, b}, 1'b1);
   endtask

   task automatic wait_cycle(input int target);
      while (cyc < target) @(negedge CLK);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge CLK);
      check32(name, 32'(exp_q.size()), 32'd0);
      repeat (4) @(negedge CLK);
   endtask

   task automatic clear_obs();
      frame_starts.delete();
      intr_pulses = 0;
      intr_high   = 0;
   endtask

   initial begin
      logic [7:0] ovf_bytes [9];
      int         s;
      int         gaps_ok;
      ovf_bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h99};

      RESET          = 1'b1;
      bus.IOBUS_ADDR = 32'd0;
      bus.IOBUS_OUT  = 32'd0;
      bus.IOBUS_WR   = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;

      // Reset state
      check32("rst_tx", {31'd0, TX}, 32'd1);
      check32("rst_intr", {31'd0, INTR}, 32'd0);
      rd_check("rst_status", BASE + 32'd4, 32'h0000_0002);
      rd_check("rst_unmapped", BASE + 32'd12, 32'd0);
      rd_check("rst_ctrl", BASE + 32'd8, 32'd0);
      rd_check("rst_data", BASE, 32'd0);

      // Decode: none of these may push
      clear_obs();
      bus_wr(BASE + 32'd16, 32'h5A, 1'b1);
      bus_wr(BASE, 32'h77, 1'b0);
      bus_wr(BASE - 32'd4, 32'h33, 1'b1);
      repeat (50) @(negedge CLK);
      rd_check("decode_status", BASE + 32'd4, 32'h0000_0002);
      check32("decode_no_frame", 32'(frame_starts.size()), 32'd0);

      // Single byte latency and length
      clear_obs();
      send(8'hA5);
      s = wr_cyc;
      wait_cycle(s + 40);
      rd_check("single_busy_last", BASE + 32'd4, 32'h0000_0006);
      @(negedge CLK);
      rd_check("single_idle", BASE + 32'd4, 32'h0000_0002);
      wait_drain("single_drain");
      check32("single_start", 32'(frame_starts.size() > 0 ? frame_starts[0] : -1), 32'(s + 1));
      check32("single_no_intr", 32'(intr_pulses), 32'd0);

      // Interrupt with IE=1
      bus_wr(BASE + 32'd8, 32'h1, 1'b1);
      rd_check("ctrl_ie", BASE + 32'd8, 32'd1);
      repeat (5) @(negedge CLK);
      check32("ie_enable_no_pulse", 32'(intr_pulses), 32'd0);
      clear_obs();
      send(8'h3A);
      send(8'hC5);
      wait_drain("intr_drain");
      check32("intr_pulses", 32'(intr_pulses), 32'd1);
      check32("intr_width", 32'(intr_high), 32'd1);
      check32("intr_time", 32'(intr_cyc),
              32'(frame_starts.size() == 2 ? frame_starts[1] + 40 : -1));

      // Same with IE=0
      bus_wr(BASE + 32'd8, 32'h0, 1'b1);
      clear_obs();
      send(8'h81);
      send(8'h7E);
      wait_drain("noie_drain");
      check32("noie_pulses", 32'(intr_pulses), 32'd0);

      // Overflow: 9 writes while a frame is underway
      clear_obs();
      send(8'h42);
      repeat (4) @(negedge CLK);
      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin
            send(ovf_bytes[i]);
         end else begin
            bus_wr(BASE, {24'd0, ovf_bytes[i]}, 1'b1);
         end
      end
      rd_check("ovf_status", BASE + 32'd4, 32'h0000_0185);
      bus_wr(BASE + 32'd4, 32'h0, 1'b1);
      rd_check("ovf_cleared", BASE + 32'd4, 32'h0000_0085);
      wait_drain("ovf_drain");
      check32("ovf_frames", 32'(frame_starts.size()), 32'd9);
      gaps_ok = 1;
      for (int i = 0; i + 1 < frame_starts.size(); i++) begin
         if (frame_starts[i+1] - frame_starts[i] != 10 * CPB) gaps_ok = 0;
      end
      check32("ovf_back_to_back", 32'(gaps_ok), 32'd1);
      rd_check("ovf_final_status", BASE + 32'd4, 32'h0000_0002);

      // Reset during DATA bit 3 with two bytes queued
      bus_wr(BASE + 32'd8, 32'h1, 1'b1);
      clear_obs();
      send(8'h0F);
      send(8'hF0);
      send(8'h66);
      for (int i = 0; i < 200 && frame_starts.size() == 0; i++) @(negedge CLK);
      check32("rstmid_started", 32'(frame_starts.size()), 32'd1);
      s = (frame_starts.size() > 0) ? frame_starts[0] : cyc;
      wait_cycle(s + 17);
      RESET = 1'b1;
      exp_q.delete();
      @(negedge CLK);
      check32("rstmid_tx", {31'd0, TX}, 32'd1);
      rd_check("rstmid_status", BASE + 32'd4, 32'h0000_0002);
      rd_check("rstmid_ctrl", BASE + 32'd8, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      repeat (120) @(negedge CLK);
      check32("rstmid_no_frame", 32'(frame_starts.size()), 32'd1);
      check32("rstmid_no_intr", 32'(intr_pulses), 32'd0);
      check32("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
